// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate generator: opcodes and format codes.
package imm_pkg;

    // Major opcodes, Inst[6:0]
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    // Immediate format codes as seen on imm_fmt
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

endpackage

// File: rtl/imm_generator_if.sv
// Decode-side bus of the immediate generator: instruction in, registered immediate out.
interface imm_generator_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] Inst;
    logic            inst_vld;
    logic [XLEN-1:0] Imm;
    logic [2:0]      imm_fmt;
    logic            imm_vld;

    // Instruction source (decode stage front end)
    modport master (
        output Inst,
        output inst_vld,
        input  Imm,
        input  imm_fmt,
        input  imm_vld
    );

    // Immediate generator
    modport slave (
        input  Inst,
        input  inst_vld,
        output Imm,
        output imm_fmt,
        output imm_vld
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decode: instruction word -> {format, sign-extended immediate}.
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:0] inst,
    output logic [2:0]  fmt,
    output logic [31:0] imm
);

    logic s;
    assign s = inst[31];

    // Classify by the full 7-bit opcode and assemble the matching immediate
    always_comb begin
        fmt = FMT_NONE;
        imm = 32'd0;
        unique case (inst[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: begin
                // Shift amounts ride in [4:0]; [11:5] pass through untouched.
                fmt = FMT_I;
                imm = {{20{s}}, inst[31:20]};
            end
            STORE: begin
                fmt = FMT_S;
                imm = {{20{s}}, inst[31:25], inst[11:7]};
            end
            BRANCH: begin
                fmt = FMT_B;
                imm = {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt = FMT_U;
                imm = {inst[31:12], 12'b0};
            end
            JAL: begin
                fmt = FMT_J;
                imm = {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                fmt = FMT_NONE;
                imm = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/imm_generator.sv
// RV32I immediate generator: registers the decoded immediate so it lines up with the
// decode/execute pipeline register. One cycle latency, never stalls.
module imm_generator
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    imm_generator_if.slave bus
);

    logic [2:0]      fmt_d;
    logic [XLEN-1:0] imm_d;
    logic [2:0]      fmt_q;
    logic [XLEN-1:0] imm_q;
    logic            vld_q;

    imm_decode u_decode (
        .inst (bus.Inst),
        .fmt  (fmt_d),
        .imm  (imm_d)
    );

    // Capture the decode on valid instructions; hold otherwise so Imm stays stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q <= '0;
            fmt_q <= FMT_NONE;
            vld_q <= 1'b0;
        end else begin
            if (bus.inst_vld) begin
                imm_q <= imm_d;
                fmt_q <= fmt_d;
            end
            vld_q <= bus.inst_vld;
        end
    end

    // Drive the registered results onto the bus
    always_comb begin
        bus.Imm     = imm_q;
        bus.imm_fmt = fmt_q;
        bus.imm_vld = vld_q;
    end

endmodule

// File: tb/tb_imm_generator.sv
// Directed self-checking bench for imm_generator with hand-computed immediates.
module tb_imm_generator;
    import imm_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    imm_generator_if #(.XLEN(32)) bus ();

    imm_generator #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus at the falling edge, then settle past the rising edge
    task automatic drive(input logic [31:0] inst, input logic vld);
        @(negedge clk);
        bus.Inst     = inst;
        bus.inst_vld = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.Inst     = 32'hfd010113;
        bus.inst_vld = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Imm !== 32'd0 || bus.imm_fmt !== FMT_NONE || bus.imm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got Imm=%h fmt=%0d vld=%b required 0/0/0",
                     bus.Imm, bus.imm_fmt, bus.imm_vld);
        end
        @(negedge clk);
        bus.inst_vld = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Imm !== 32'd0 || bus.imm_fmt !== FMT_NONE || bus.imm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got Imm=%h fmt=%0d vld=%b required 0/0/0",
                     bus.Imm, bus.imm_fmt, bus.imm_vld);
        end
    endtask

    // One vector per format plus per-field bit probes
    task automatic test_formats();
        logic [31:0] insts [14];
        logic [2:0]  fmts  [14];
        logic [31:0] imms  [14];
        string       names [14];
        insts = '{32'hfd010113, 32'h02812623, 32'h00f71863, 32'h0000b7b7, 32'h00c0006f,
                  32'hffc42503, 32'h30029073, 32'h00008067, 32'hfffff517, 32'hfe002fa3,
                  32'h000000e3, 32'h0010006f, 32'h000ff06f, 32'h4030d093};
        fmts  = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_J,
                  FMT_I, FMT_I, FMT_I, FMT_U, FMT_S,
                  FMT_B, FMT_J, FMT_J, FMT_I};
        imms  = '{32'hffffffd0, 32'h0000002c, 32'h00000010, 32'h0000b000, 32'h0000000c,
                  32'hfffffffc, 32'h00000300, 32'h00000000, 32'hfffff000, 32'hffffffff,
                  32'h00000800, 32'h00000800, 32'h000ff000, 32'h00000403};
        names = '{"addi", "sw", "bne", "lui", "jal",
                  "lw_neg", "csrrw", "jalr", "auipc_neg", "sw_neg",
                  "b_bit11", "j_bit11", "j_19_12", "srai"};
        for (int i = 0; i < 14; i++) begin
            drive(insts[i], 1'b1);
            n_cmp++;
            if (bus.imm_fmt !== fmts[i]) begin
                n_err++;
                $display("FAIL fmt_%s: got %0d required %0d", names[i], bus.imm_fmt, fmts[i]);
            end
            n_cmp++;
            if (bus.Imm !== imms[i]) begin
                n_err++;
                $display("FAIL imm_%s: got %h required %h", names[i], bus.Imm, imms[i]);
            end
            n_cmp++;
            if (bus.imm_vld !== 1'b1) begin
                n_err++;
                $display("FAIL vld_%s: got %b required 1", names[i], bus.imm_vld);
            end
        end
    endtask

    task automatic test_extremes();
        drive(32'h80000063, 1'b1);
        n_cmp++;
        if (bus.Imm !== 32'hfffff000 || bus.imm_fmt !== FMT_B) begin
            n_err++;
            $display("FAIL b_min: got Imm=%h fmt=%0d required fffff000/%0d",
                     bus.Imm, bus.imm_fmt, FMT_B);
        end
        drive(32'h8000006f, 1'b1);
        n_cmp++;
        if (bus.Imm !== 32'hfff00000 || bus.imm_fmt !== FMT_J) begin
            n_err++;
            $display("FAIL j_min: got Imm=%h fmt=%0d required fff00000/%0d",
                     bus.Imm, bus.imm_fmt, FMT_J);
        end
    endtask

    // Unknown opcodes, including ones whose low bits are not 2'b11, must give NONE/0
    task automatic test_none();
        logic [31:0] insts [3];
        insts = '{32'hfff0000b, 32'hfff00010, 32'hfff00000};
        for (int i = 0; i < 3; i++) begin
            drive(32'hfd010113, 1'b1);
            drive(insts[i], 1'b1);
            n_cmp++;
            if (bus.Imm !== 32'd0 || bus.imm_fmt !== FMT_NONE || bus.imm_vld !== 1'b1) begin
                n_err++;
                $display("FAIL none_%0d: got Imm=%h fmt=%0d vld=%b required 0/0/1",
                         i, bus.Imm, bus.imm_fmt, bus.imm_vld);
            end
        end
    endtask

    task automatic test_hold();
        drive(32'h02812623, 1'b1);
        drive(32'h00c0006f, 1'b0);
        n_cmp++;
        if (bus.imm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL hold_vld: got %b required 0", bus.imm_vld);
        end
        drive(32'h8000006f, 1'b0);
        n_cmp++;
        if (bus.Imm !== 32'h0000002c || bus.imm_fmt !== FMT_S) begin
            n_err++;
            $display("FAIL hold_imm: got Imm=%h fmt=%0d required 0000002c/%0d",
                     bus.Imm, bus.imm_fmt, FMT_S);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        insts = '{32'h00f71863, 32'h0000b7b7, 32'h80000063, 32'hfd010113};
        imms  = '{32'h00000010, 32'h0000b000, 32'hfffff000, 32'hffffffd0};
        for (int i = 0; i < 4; i++) begin
            drive(insts[i], 1'b1);
            n_cmp++;
            if (bus.Imm !== imms[i] || bus.imm_vld !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_%0d: got Imm=%h vld=%b required %h/1",
                         i, bus.Imm, bus.imm_vld, imms[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(32'h00c0006f, 1'b1);
        // Mid-cycle, no clock edge between assert and check
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.Imm !== 32'd0 || bus.imm_fmt !== FMT_NONE || bus.imm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: got Imm=%h fmt=%0d vld=%b required 0/0/0",
                     bus.Imm, bus.imm_fmt, bus.imm_vld);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Imm !== 32'd0 || bus.imm_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drop: got Imm=%h vld=%b required 0/0", bus.Imm, bus.imm_vld);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0000b7b7, 1'b1);
        n_cmp++;
        if (bus.Imm !== 32'h0000b000 || bus.imm_fmt !== FMT_U || bus.imm_vld !== 1'b1) begin
            n_err++;
            $display("FAIL after_rst: got Imm=%h fmt=%0d vld=%b required 0000b000/%0d/1",
                     bus.Imm, bus.imm_fmt, bus.imm_vld, FMT_U);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_formats();
        test_extremes();
        test_none();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
